// File: rtl/usb_pid_pkg.sv
// Shared types for the receive-path PID dispatcher: packet classes, PID codes, FSM states.
package usb_pid_pkg;

   typedef enum logic [3:0] {
      PKT_INVALID = 4'd0,
      PKT_OUT     = 4'd1,
      PKT_IN      = 4'd2,
      PKT_SETUP   = 4'd3,
      PKT_SOF     = 4'd4,
      PKT_DATA0   = 4'd5,
      PKT_DATA1   = 4'd6,
      PKT_ACK     = 4'd7,
      PKT_NAK     = 4'd8,
      PKT_STALL   = 4'd9,
      PKT_OTHER   = 4'd10
   } pkt_type_t;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_SOF   = 4'b0101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

endpackage

// File: rtl/pid_decoder.sv
// Combinational PID byte decoder: integrity check, classification, data-toggle bit.
module pid_decoder
   import usb_pid_pkg::*;
(
   input  logic [7:0] i_pid,
   output pkt_type_t  o_type,
   output logic       o_pid_ok,
   output logic       o_is_data,
   output logic       o_data_bit
);

   always_comb begin
      o_pid_ok   = (i_pid[7:4] == ~i_pid[3:0]);
      o_type     = PKT_INVALID;
      o_is_data  = 1'b0;
      o_data_bit = i_pid[3];
      if (o_pid_ok) begin
         case (i_pid[3:0])
            PID_OUT:   o_type = PKT_OUT;
            PID_IN:    o_type = PKT_IN;
            PID_SETUP: o_type = PKT_SETUP;
            PID_SOF:   o_type = PKT_SOF;
            PID_DATA0: begin o_type = PKT_DATA0; o_is_data = 1'b1; end
            PID_DATA1: begin o_type = PKT_DATA1; o_is_data = 1'b1; end
            PID_ACK:   o_type = PKT_ACK;
            PID_NAK:   o_type = PKT_NAK;
            PID_STALL: o_type = PKT_STALL;
            default:   o_type = PKT_OTHER;
         endcase
      end
   end

endmodule

// File: rtl/pid_dispatcher.sv
// Pops PIDs from the receive FIFO, classifies them, tracks the data toggle and
// presents one descriptor at a time on a valid/ready interface.
module pid_dispatcher
   import usb_pid_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 fifo_empty,
   input  logic [7:0]           fifo_r_data,
   output logic                 fifo_r_enable,
   input  logic                 pkt_ready,
   output logic                 pkt_valid,
   output logic [3:0]           pkt_type,
   output logic [7:0]           pkt_pid,
   output logic                 pid_err,
   output logic                 toggle_err,
   output logic                 exp_toggle,
   output logic [ERR_CNT_W-1:0] err_count
);

   state_t                r_state, w_state_nxt;
   pkt_type_t             r_type;
   logic [7:0]            r_pid;
   logic                  r_pid_err, r_tog_err, r_exp_tog;
   logic [ERR_CNT_W-1:0]  r_err_cnt;

   pkt_type_t             w_type;
   logic                  w_pid_ok, w_is_data, w_data_bit;
   logic                  w_load, w_tog_err, w_err;

   pid_decoder u_dec (
      .i_pid      (fifo_r_data),
      .o_type     (w_type),
      .o_pid_ok   (w_pid_ok),
      .o_is_data  (w_is_data),
      .o_data_bit (w_data_bit)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (!fifo_empty) w_state_nxt = ST_PRESENT;
         ST_PRESENT: if (pkt_ready && fifo_empty) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      pkt_valid = (r_state == ST_PRESENT);
      w_load    = !fifo_empty && ((r_state == ST_IDLE) || pkt_ready);
   end

   // Keep the pop strobe quiet while reset is held, even if the FIFO has data.
   assign fifo_r_enable = w_load & n_rst;

   assign w_tog_err = w_is_data && (w_data_bit != r_exp_tog);
   assign w_err     = !w_pid_ok || w_tog_err;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_type    <= PKT_INVALID;
         r_pid     <= 8'h00;
         r_pid_err <= 1'b0;
         r_tog_err <= 1'b0;
         r_exp_tog <= 1'b0;
         r_err_cnt <= '0;
      end else if (w_load) begin
         r_type    <= w_type;
         r_pid     <= fifo_r_data;
         r_pid_err <= !w_pid_ok;
         r_tog_err <= w_tog_err;
         if (w_type == PKT_SETUP)
            r_exp_tog <= 1'b0;
         else if (w_is_data && !w_tog_err)
            r_exp_tog <= ~r_exp_tog;
         if (w_err && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   assign pkt_type   = r_type;
   assign pkt_pid    = r_pid;
   assign pid_err    = r_pid_err;
   assign toggle_err = r_tog_err;
   assign exp_toggle = r_exp_tog;
   assign err_count  = r_err_cnt;

endmodule

// File: tb/tb_pid_dispatcher.sv
// Scoreboard bench for pid_dispatcher: a FIFO model feeds bytes, a reference model
// predicts each descriptor, and handshakes are compared against the predictions.
module tb_pid_dispatcher;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        fifo_empty;
   logic [7:0]  fifo_r_data;
   logic        fifo_r_enable;
   logic        pkt_ready;
   logic        pkt_valid;
   logic [3:0]  pkt_type;
   logic [7:0]  pkt_pid;
   logic        pid_err, toggle_err, exp_toggle;
   logic [7:0]  err_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  mem [0:1023];
   logic [10:0] wr_ptr = '0;
   logic [10:0] rd_ptr = '0;

   logic [22:0] exp_q [$];
   logic        m_tog;
   logic [7:0]  m_err;

   always #5 clk = ~clk;

   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_r_data = mem[rd_ptr[9:0]];

   pid_dispatcher #(.ERR_CNT_W(8)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .fifo_empty    (fifo_empty),
      .fifo_r_data   (fifo_r_data),
      .fifo_r_enable (fifo_r_enable),
      .pkt_ready     (pkt_ready),
      .pkt_valid     (pkt_valid),
      .pkt_type      (pkt_type),
      .pkt_pid       (pkt_pid),
      .pid_err       (pid_err),
      .toggle_err    (toggle_err),
      .exp_toggle    (exp_toggle),
      .err_count     (err_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [22:0] snap();
      return {pkt_type, pkt_pid, pid_err, toggle_err, exp_toggle, err_count};
   endfunction

   // Reference model: table of the nine known full PID bytes, everything else by check.
   task automatic push(input logic [7:0] b);
      logic [3:0] t;
      logic       perr, terr;
      mem[wr_ptr[9:0]] = b;
      wr_ptr = wr_ptr + 11'd1;
      case (b)
         8'hE1: t = 4'd1;
         8'h69: t = 4'd2;
         8'h2D: t = 4'd3;
         8'hA5: t = 4'd4;
         8'hC3: t = 4'd5;
         8'h4B: t = 4'd6;
         8'hD2: t = 4'd7;
         8'h5A: t = 4'd8;
         8'h1E: t = 4'd9;
         default: t = ((b[7:4] ^ b[3:0]) == 4'hF) ? 4'd10 : 4'd0;
      endcase
      perr = (t == 4'd0);
      terr = 1'b0;
      if (t == 4'd3) m_tog = 1'b0;
      if (t == 4'd5 || t == 4'd6) begin
         if ((t == 4'd6) == m_tog) m_tog = ~m_tog;
         else terr = 1'b1;
      end
      if ((perr || terr) && m_err != 8'hFF) m_err = m_err + 8'd1;
      exp_q.push_back({t, b, perr, terr, m_tog, m_err});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && !pkt_valid && fifo_empty) done = 1;
      end
      if (!done) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   always @(posedge clk)
      if (fifo_r_enable) rd_ptr <= rd_ptr + 11'd1;

   always @(negedge clk) begin
      if (n_rst && pkt_valid && pkt_ready) begin
         if (exp_q.size() == 0) chk("unexpected_desc", {9'd0, snap()}, 32'hFFFF_FFFF);
         else chk("desc", {9'd0, snap()}, {9'd0, exp_q.pop_front()});
      end
   end

   initial begin
      logic [22:0] held;
      logic [2:0]  tog_seq;
      n_rst = 1'b0;
      pkt_ready = 1'b0;
      m_tog = 1'b0;
      m_err = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, pkt_valid}, 32'd0);
      chk("rst_state", {9'd0, snap()}, 32'd0);
      chk("rst_ren", {31'd0, fifo_r_enable}, 32'd0);
      n_rst = 1'b1;

      // SETUP: pop at the first edge, descriptor visible right after it
      tick();
      push(8'h2D);
      @(negedge clk);
      chk("setup_pre_valid", {31'd0, pkt_valid}, 32'd0);
      chk("setup_pop", {31'd0, fifo_r_enable}, 32'd1);
      @(negedge clk);
      chk("setup_valid", {31'd0, pkt_valid}, 32'd1);
      chk("setup_type", {28'd0, pkt_type}, 32'd3);
      chk("setup_tog", {31'd0, exp_toggle}, 32'd0);
      tick();
      pkt_ready = 1'b1;
      tick();
      pkt_ready = 1'b0;
      @(negedge clk);
      chk("setup_done_valid", {31'd0, pkt_valid}, 32'd0);

      // Back-to-back DATA0/DATA1/DATA0
      tick();
      pkt_ready = 1'b1;
      push(8'hC3); push(8'h4B); push(8'hC3);
      @(negedge clk);
      tog_seq = 3'b101;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("b2b_valid", {31'd0, pkt_valid}, 32'd1);
         chk("b2b_tog", {31'd0, exp_toggle}, {31'd0, tog_seq[2-k]});
      end
      drain(50);

      // DATA1 right after SETUP is a toggle error
      push(8'h2D); push(8'h4B);
      drain(50);
      chk("togerr_flag", {31'd0, toggle_err}, 32'd1);
      chk("togerr_exp", {31'd0, exp_toggle}, 32'd0);
      chk("togerr_cnt", {24'd0, err_count}, 32'd1);

      // Corrupted PID
      push(8'h2C);
      drain(50);
      chk("bad_type", {28'd0, pkt_type}, 32'd0);
      chk("bad_pid_err", {31'd0, pid_err}, 32'd1);
      chk("bad_cnt", {24'd0, err_count}, 32'd2);
      chk("bad_exp", {31'd0, exp_toggle}, 32'd0);

      // Backpressure: three queued, outputs frozen while not ready
      pkt_ready = 1'b0;
      tick();
      push(8'hE1); push(8'h69); push(8'hA5);
      @(negedge clk);
      @(negedge clk);
      held = snap();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_hold", {9'd0, snap()}, {9'd0, held});
         chk("stall_valid", {31'd0, pkt_valid}, 32'd1);
         chk("stall_ren", {31'd0, fifo_r_enable}, 32'd0);
      end
      tick();
      pkt_ready = 1'b1;
      push(8'hD2); push(8'h5A); push(8'h1E); push(8'h0F);
      drain(50);

      // Reset while presenting with data still queued
      pkt_ready = 1'b0;
      push(8'hE1); push(8'hD2);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_valid", {31'd0, pkt_valid}, 32'd1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, pkt_valid}, 32'd0);
      chk("mid_rst_state", {9'd0, snap()}, 32'd0);
      chk("mid_rst_ren", {31'd0, fifo_r_enable}, 32'd0);
      wr_ptr = rd_ptr;
      exp_q.delete();
      m_tog = 1'b0;
      m_err = 8'd0;
      tick();
      n_rst = 1'b1;

      // Saturation of the error counter
      pkt_ready = 1'b1;
      for (int k = 0; k < 300; k++) push(8'h2C);
      drain(1000);
      chk("sat_cnt", {24'd0, err_count}, 32'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
